// File: rtl/accum33_frame.sv
// Streaming signed accumulator into a 33-bit sum, one result per frame over valid/ready.
// Define ACCUM33_SAT_EN to saturate on overflow instead of zeroing the running sum.
module accum33_frame #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned FRAME_LEN = 16,
    parameter int unsigned CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [32:0]       out_sum,
    output logic              out_ovf,
    output logic [CNT_W-1:0]  out_count
);

    typedef enum logic {StAcc, StHold} state_e;

    state_e             state_q, state_d;
    logic [32:0]        sum_q, sum_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [32:0]        addend;
    logic [32:0]        raw_sum;
    logic               add_ovf;
    logic               accept;
    logic [CNT_W-1:0]   count_inc;
    logic [32:0]        ovf_sum;

    assign addend    = {{(33 - DATA_W){in_data[DATA_W-1]}}, in_data};
    assign raw_sum   = sum_q + addend;
    assign add_ovf   = (sum_q[32] == addend[32]) & (raw_sum[32] != sum_q[32]);
    assign accept    = in_valid & (state_q == StAcc);
    assign count_inc = count_q + CNT_W'(1);

`ifdef ACCUM33_SAT_EN
    // Clamp toward the sign of the pre-add sum.
    assign ovf_sum = sum_q[32] ? 33'h1_0000_0000 : 33'h0_FFFF_FFFF;
`else
    assign ovf_sum = 33'h0;
`endif

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        count_d = count_q;
        unique case (state_q)
            StAcc: begin
                if (accept) begin
                    sum_d   = add_ovf ? ovf_sum : raw_sum;
                    ovf_d   = ovf_q | add_ovf;
                    count_d = count_inc;
                    if (count_inc == CNT_W'(FRAME_LEN) || flush) begin
                        state_d = StHold;
                    end
                end else if (flush && count_q != '0) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (out_ready) begin
                    state_d = StAcc;
                    sum_d   = '0;
                    ovf_d   = 1'b0;
                    count_d = '0;
                end
            end
            default: state_d = StAcc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StAcc;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
        end
    end

    assign in_ready  = (state_q == StAcc);
    assign out_valid = (state_q == StHold);
    assign out_sum   = sum_q;
    assign out_ovf   = ovf_q;
    assign out_count = count_q;

endmodule

// File: tb/tb_accum33_frame.sv
// Self-checking bench for accum33_frame with a frame-level arithmetic reference model.
module tb_accum33_frame;

    localparam int unsigned FrameLen = 4;
    localparam longint MaxV = 64'sd4294967295;
    localparam longint MinV = -64'sd4294967296;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [32:0] out_sum;
    logic        out_ovf;
    logic [7:0]  out_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    longint m_sum  = 0;
    bit     m_ovf  = 0;
    int     m_cnt  = 0;
    bit     m_hold = 0;

    always #5 clk = ~clk;

    accum33_frame #(
        .DATA_W    (32),
        .FRAME_LEN (FrameLen),
        .CNT_W     (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .out_count (out_count)
    );

    function automatic logic [32:0] exp_sum();
        longint t = m_sum;
        return t[32:0];
    endfunction

    task automatic model_step(input bit rs, input bit v, input logic [31:0] d,
                              input bit f, input bit r);
        longint a;
        longint s;
        if (rs) begin
            m_sum = 0; m_ovf = 0; m_cnt = 0; m_hold = 0;
        end else if (!m_hold) begin
            if (v) begin
                a = longint'($signed(d));
                s = m_sum + a;
                if (s > MaxV || s < MinV) begin
`ifdef ACCUM33_SAT_EN
                    m_sum = (m_sum >= 0) ? MaxV : MinV;
`else
                    m_sum = 0;
`endif
                    m_ovf = 1;
                end else begin
                    m_sum = s;
                end
                m_cnt++;
                if (m_cnt == FrameLen || f) m_hold = 1;
            end else if (f && m_cnt > 0) begin
                m_hold = 1;
            end
        end else if (r) begin
            m_sum = 0; m_ovf = 0; m_cnt = 0; m_hold = 0;
        end
    endtask

    // Drive one cycle of inputs, advance the model, and settle just after the edge.
    task automatic step(input bit rs, input bit v, input logic [31:0] d,
                        input bit f, input bit r);
        rst = rs; in_valid = v; in_data = d; flush = f; out_ready = r;
        model_step(rs, v, d, f, r);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1, 1, 32'h1234, 1, 0);
        step(0, 0, 0, 0, 0);
        n_checks += 5;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        if (out_sum !== 33'h0) begin n_fail++; $display("FAIL reset_sum got %h want 0", out_sum); end
        if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", out_ovf); end
        if (out_count !== 8'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", out_count); end
    endtask

    task automatic test_basic();
        int vals [4] = '{1, 2, 3, -10};
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 32'(vals[i]), 0, 0);
        end
        n_checks += 5;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b want 1", out_valid); end
        if (out_sum !== 33'h1_FFFF_FFFC) begin n_fail++; $display("FAIL basic_sum got %h want 1fffffffc", out_sum); end
        if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL basic_ovf got %b want 0", out_ovf); end
        if (out_count !== 8'd4) begin n_fail++; $display("FAIL basic_count got %0d want 4", out_count); end
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_hold_ready got %b want 0", in_ready); end
        step(0, 0, 0, 0, 1);
        n_checks += 2;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_release_ready got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_release_valid got %b want 0", out_valid); end
    endtask

    task automatic test_overflow_pos();
        logic [32:0] want;
`ifdef ACCUM33_SAT_EN
        want = 33'h0_FFFF_FFFF;
`else
        want = 33'h0_0000_0005;
`endif
        for (int i = 0; i < 3; i++) step(0, 1, 32'h7FFF_FFFF, 0, 0);
        step(0, 1, 32'd5, 0, 0);
        n_checks += 4;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_pos_valid got %b want 1", out_valid); end
        if (out_sum !== want) begin n_fail++; $display("FAIL ovf_pos_sum got %h want %h", out_sum, want); end
        if (out_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_pos_flag got %b want 1", out_ovf); end
        if (out_count !== 8'd4) begin n_fail++; $display("FAIL ovf_pos_count got %0d want 4", out_count); end
        step(0, 0, 0, 0, 1);
    endtask

    task automatic test_overflow_neg();
        logic [32:0] want;
`ifdef ACCUM33_SAT_EN
        want = 33'h1_0000_0000;
`else
        want = 33'h0;
`endif
        step(0, 1, 32'h8000_0000, 0, 0);
        step(0, 1, 32'h8000_0000, 0, 0);
        step(0, 1, 32'h8000_0000, 1, 0);
        n_checks += 3;
        if (out_sum !== want) begin n_fail++; $display("FAIL ovf_neg_sum got %h want %h", out_sum, want); end
        if (out_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_neg_flag got %b want 1", out_ovf); end
        if (out_count !== 8'd3) begin n_fail++; $display("FAIL ovf_neg_count got %0d want 3", out_count); end
        step(0, 0, 0, 0, 1);
    endtask

    task automatic test_flush();
        step(0, 1, 32'd7, 0, 0);
        step(0, 1, 32'd9, 1, 0);
        n_checks += 3;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_valid got %b want 1", out_valid); end
        if (out_sum !== 33'd16) begin n_fail++; $display("FAIL flush_sum got %h want 10", out_sum); end
        if (out_count !== 8'd2) begin n_fail++; $display("FAIL flush_count got %0d want 2", out_count); end
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, 1);
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty_valid cyc %0d got %b want 0", i, out_valid); end
        end
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_backpressure();
        logic [32:0] held_sum;
        logic [7:0]  held_cnt;
        logic        held_ovf;
        for (int i = 0; i < 4; i++) step(0, 1, $urandom_range(0, 1000), 0, 0);
        held_sum = out_sum; held_cnt = out_count; held_ovf = out_ovf;
        n_checks++;
        if (held_sum !== exp_sum()) begin n_fail++; $display("FAIL bp_sum got %h want %h", held_sum, exp_sum()); end
        for (int i = 0; i < 5; i++) begin
            step(0, 1, $urandom, i == 2, 0);
            n_checks += 5;
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready cyc %0d got %b want 0", i, in_ready); end
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid cyc %0d got %b want 1", i, out_valid); end
            if (out_sum !== held_sum) begin n_fail++; $display("FAIL bp_sum_stable cyc %0d got %h want %h", i, out_sum, held_sum); end
            if (out_count !== held_cnt) begin n_fail++; $display("FAIL bp_count_stable cyc %0d got %0d want %0d", i, out_count, held_cnt); end
            if (out_ovf !== held_ovf) begin n_fail++; $display("FAIL bp_ovf_stable cyc %0d got %b want %b", i, out_ovf, held_ovf); end
        end
        step(0, 0, 0, 0, 1);
        n_checks += 2;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
        if (out_count !== 8'd0) begin n_fail++; $display("FAIL bp_release_count got %0d want 0", out_count); end
    endtask

    task automatic test_reset_mid();
        step(0, 1, 32'd100, 0, 0);
        step(0, 1, 32'd200, 0, 0);
        step(1, 1, 32'd300, 0, 0);
        n_checks += 3;
        if (out_sum !== 33'h0) begin n_fail++; $display("FAIL rmid_sum got %h want 0", out_sum); end
        if (out_count !== 8'd0) begin n_fail++; $display("FAIL rmid_count got %0d want 0", out_count); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %b want 0", out_valid); end
        for (int i = 0; i < 4; i++) step(0, 1, 32'd1, 0, 0);
        n_checks += 2;
        if (out_sum !== 33'd4) begin n_fail++; $display("FAIL rmid_frame_sum got %h want 4", out_sum); end
        if (out_count !== 8'd4) begin n_fail++; $display("FAIL rmid_frame_count got %0d want 4", out_count); end
        step(0, 0, 0, 0, 1);
    endtask

    task automatic test_random();
        logic [31:0] d;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: d = $urandom_range(0, 15);
                1: d = -$urandom_range(0, 15);
                default: d = $urandom;
            endcase
            step(0, $urandom_range(0, 3) != 0, d, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 2) != 0);
            n_checks += 2;
            if (in_ready !== !m_hold) begin n_fail++; $display("FAIL rand_ready cyc %0d got %b want %b", i, in_ready, !m_hold); end
            if (out_valid !== m_hold) begin n_fail++; $display("FAIL rand_valid cyc %0d got %b want %b", i, out_valid, m_hold); end
            if (m_hold) begin
                n_checks += 3;
                if (out_sum !== exp_sum()) begin n_fail++; $display("FAIL rand_sum cyc %0d got %h want %h", i, out_sum, exp_sum()); end
                if (out_ovf !== m_ovf) begin n_fail++; $display("FAIL rand_ovf cyc %0d got %b want %b", i, out_ovf, m_ovf); end
                if (out_count !== 8'(m_cnt)) begin n_fail++; $display("FAIL rand_count cyc %0d got %0d want %0d", i, out_count, m_cnt); end
            end
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_overflow_pos();
        test_overflow_neg();
        test_flush();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/accum33_frame.md
Name: accum33_frame

Overview:
- Streaming signed accumulator that feeds the team's 33-bit ripple adder datapath convention.
- Accepts DATA_W-bit signed samples over a valid/ready handshake and sign-extends each to 33 bits.
- Adds each sample into a 33-bit running sum. On signed overflow the sum is zeroed, matching the 33-bit adder's S & ~O rule.
- Emits one result per frame (FRAME_LEN samples, or fewer on flush) over a valid/ready output handshake.

Parameters:
- DATA_W, 32, input sample width in bits, signed two's complement. Legal range 2..32.
- FRAME_LEN, 16, samples per frame. Legal range 1..255.
- CNT_W, 8, width of the sample counter and out_count. Must hold FRAME_LEN.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  sample present on in_data.
- in_ready  output  1  block can accept a sample this cycle.
- in_data  input  DATA_W  signed sample.
- flush  input  1  close the current frame early.
- out_valid  output  1  frame result available.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  33  signed frame sum.
- out_ovf  output  1  sticky: at least one overflow occurred in this frame.
- out_count  output  CNT_W  samples accumulated in this frame.

Behaviour:
- Interface (already decided): one clock (clk); reset rst is synchronous and active-high.
- Reset, sampled at a clk edge with rst=1:
  - state=ACC, sum=0, ovf=0, count=0.
  - out_valid=0, in_ready=1 the cycle after reset.
  - Reset overrides any in-flight handshake; a partial frame is discarded.
- States: ACC and HOLD.
- ACC:
  - in_ready=1, out_valid=0.
  - Accept when in_valid&in_ready. Then:
    - a = sign-extend in_data to 33 bits;
    - r = sum + a, computed as 33-bit two's complement;
    - O = (sum[32]==a[32]) & (r[32]!=sum[32]).
    - If O: sum <= 0 and ovf <= 1. Otherwise sum <= r.
    - count <= count+1.
  - After an overflow, accumulation restarts from 0 on the next sample.
- ACC to HOLD transition occurs when either condition holds:
  - an accepted sample brings count to FRAME_LEN;
  - flush=1 and (count>0 or a sample is accepted the same cycle).
- Flush and accepted sample in the same cycle: the sample is included, then the block goes to HOLD.
- flush with count==0 and no accepted sample is ignored. Zero-sample frames are never emitted.
- HOLD:
  - in_ready=0, out_valid=1.
  - out_sum, out_ovf, out_count are registered and stable until the handshake.
  - flush is ignored.
- HOLD to ACC on out_valid&out_ready. Same edge: sum=0, ovf=0, count=0.
- in_ready rises the following cycle.
- Latency:
  - out_valid asserts the cycle after the closing sample or flush.
  - Minimum frame period is FRAME_LEN+1 cycles.
- out_* values are don't-care while out_valid=0, but must be driven; implementations drive the live registers.
- in_data is sampled only on an accept. No combinational path from in_valid to in_ready.

Optional Feature:
- Macro: ACCUM33_SAT_EN.
- Defined:
  - on overflow, sum saturates instead of zeroing: +0x0_FFFF_FFFF (2^32-1) if sum was positive, 0x1_0000_0000 (-2^32) if negative;
  - ovf is still set;
  - later samples add to the saturated value under the same rules.
- Undefined: zero-on-overflow, as described in Behaviour.

Test Plan:
- Reset then 4 samples 1,2,3,-10 with FRAME_LEN=4 and out_ready=1 → out_valid 1 cycle after the 4th accept; out_sum=0x1_FFFF_FFFC (-4), out_ovf=0, out_count=4.
- FRAME_LEN=4, samples 0x7FFFFFFF x3 then 5:
  - 3rd add overflows, so sum=0 and ovf=1;
  - out_sum=5, out_ovf=1, out_count=4;
  - with ACCUM33_SAT_EN: out_sum=0x0_FFFF_FFFF.
- ACCUM33_SAT_EN defined, samples 0x80000000 x3 → out_sum=0x1_0000_0000, out_ovf=1.
- Samples 7 and 9, with flush asserted together with the 9 accept → out_sum=16, out_count=2. Then flush alone with count=0 → no out_valid.
- out_ready held 0 for 5 cycles in HOLD → in_ready=0 and out_* stable throughout. out_ready=1 → next cycle in_ready=1, new frame count starts at 0.
- rst asserted mid-frame after 2 samples → next cycle sum=0, count=0, out_valid=0. The following full frame of 4x1 gives out_sum=4.
